// File: rtl/parallel_add_pkg.sv
// Shared definitions for the parallel add pipeline: mode encoding and the
// per-lane add-with-wrap/saturate arithmetic used by every lane instance.
package parallel_add_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest lane the helper supports; lanes narrower than this are handled
    // by masking down to the requested width.
    localparam int LANE_MAX_W = 64;

    // Adds incr to a within a width-bit field. The sum keeps one extra bit,
    // so the bit above the field is the carry. In saturate mode a carry clamps
    // the result to all-ones; in wrap mode it is simply dropped.
    function automatic logic [LANE_MAX_W-1:0] lane_add(
        input logic [LANE_MAX_W-1:0] a,
        input logic [LANE_MAX_W-1:0] incr,
        input logic                  sat,
        input int                    width
    );
        logic [LANE_MAX_W-1:0] mask;
        logic [LANE_MAX_W:0]   sum;
        logic                  carry;
        mask  = {LANE_MAX_W{1'b1}} >> (LANE_MAX_W - width);
        sum   = {1'b0, a & mask} + {1'b0, incr & mask};
        carry = |(sum >> width);
        if (sat == MODE_SAT && carry) begin
            lane_add = mask;
        end else begin
            lane_add = sum[LANE_MAX_W-1:0] & mask;
        end
    endfunction

endpackage

// File: rtl/parallel_add_lane.sv
// One lane of the datapath: a WIDTH-bit constant add with wrap or saturate.
// Purely combinational; the pipeline registers live in the top module.
module parallel_add_lane #(
    parameter int          WIDTH = 8,
    parameter int unsigned INCR  = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic             sat,
    output logic [WIDTH-1:0] y
);
    import parallel_add_pkg::*;

    // The helper masks INCR to WIDTH bits, which gives the truncation of an
    // oversized constant for free.
    localparam logic [LANE_MAX_W-1:0] INCR_EXT = LANE_MAX_W'(INCR);

    // Lane result: widen the operand, add, and keep the low WIDTH bits.
    always_comb begin
        y = WIDTH'(lane_add(LANE_MAX_W'(a), INCR_EXT, sat, WIDTH));
    end

endmodule

// File: rtl/parallel_add_pipe.sv
// Multi-lane "+INCR" datapath behind a STAGES-deep valid/ready pipeline.
// Every stage can advance independently, so bubbles collapse and the block
// holds up to STAGES beats under backpressure without ever overwriting a
// valid stalled stage.
module parallel_add_pipe #(
    parameter int          WIDTH  = 8,
    parameter int          LANES  = 4,
    parameter int          STAGES = 2,
    parameter int unsigned INCR   = 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   CE,
    input  logic [LANES*WIDTH-1:0] I,
    input  logic                   sat_mode,
    input  logic                   valid_data_in,
    output logic                   ready_data_in,
    output logic [LANES*WIDTH-1:0] O,
    output logic                   valid_data_out,
    input  logic                   ready_data_out
);
    import parallel_add_pkg::*;

    localparam int DW = LANES * WIDTH;

    logic [DW-1:0]     lane_result;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] adv;
    logic [DW-1:0]     stage_data [STAGES];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        parallel_add_lane #(
            .WIDTH (WIDTH),
            .INCR  (INCR)
        ) u_lane (
            .a   (I[k*WIDTH +: WIDTH]),
            .sat (sat_mode),
            .y   (lane_result[k*WIDTH +: WIDTH])
        );
    end

    // A stage may advance when downstream takes the output or when any stage
    // from it to the output is empty; written flat to avoid a bit-serial loop.
    always_comb begin
        adv = '0;
        for (int s = 0; s < STAGES; s++) begin
            adv[s] = ready_data_out |
                     (|(~stage_valid & ({STAGES{1'b1}} << s)));
        end
    end

    // Stage registers: stage 0 captures the lane results, later stages shift
    // forward whenever they are allowed to advance; CE low freezes everything.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            stage_valid <= '0;
            for (int s = 0; s < STAGES; s++) begin
                stage_data[s] <= '0;
            end
        end else if (CE) begin
            if (adv[0]) begin
                stage_valid[0] <= valid_data_in;
                stage_data[0]  <= lane_result;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (adv[s]) begin
                    stage_valid[s] <= stage_valid[s-1];
                    stage_data[s]  <= stage_data[s-1];
                end
            end
        end
    end

    assign ready_data_in  = CE & adv[0];
    assign valid_data_out = CE & stage_valid[STAGES-1];
    assign O              = stage_data[STAGES-1];

endmodule

// File: tb/tb_parallel_add_pipe.sv
// Self-checking bench for parallel_add_pipe: directed scenarios plus a
// randomized phase, all outputs compared against a queue-based model.
module tb_parallel_add_pipe;

    localparam int W  = 8;
    localparam int L  = 4;
    localparam int DW = W * L;
    localparam int BW = 16;
    localparam int BL = 3;
    localparam int BDW = BW * BL;

    logic           CLK = 1'b0;
    logic           RESET, CE, sat_mode, valid_data_in, ready_data_in;
    logic           valid_data_out, ready_data_out;
    logic [DW-1:0]  I, O;

    logic           b_sat_mode, b_valid_data_in, b_ready_data_in;
    logic           b_valid_data_out;
    logic           b_ce, b_ready_data_out;
    logic [BDW-1:0] b_I, b_O;

    int             num_checks = 0;
    int             num_errors = 0;
    logic [DW-1:0]  exp_q [$];
    int             in_count = 0;
    int             out_count = 0;
    bit             mon_en = 1'b0;
    bit             prev_stall = 1'b0;
    logic [DW-1:0]  prev_o = '0;

    always #5 CLK = ~CLK;

    parallel_add_pipe #(
        .WIDTH (W), .LANES (L), .STAGES (2), .INCR (1)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .CE             (CE),
        .I              (I),
        .sat_mode       (sat_mode),
        .valid_data_in  (valid_data_in),
        .ready_data_in  (ready_data_in),
        .O              (O),
        .valid_data_out (valid_data_out),
        .ready_data_out (ready_data_out)
    );

    parallel_add_pipe #(
        .WIDTH (BW), .LANES (BL), .STAGES (4), .INCR (32'h0100)
    ) dut_wide (
        .CLK            (CLK),
        .RESET          (RESET),
        .CE             (b_ce),
        .I              (b_I),
        .sat_mode       (b_sat_mode),
        .valid_data_in  (b_valid_data_in),
        .ready_data_in  (b_ready_data_in),
        .O              (b_O),
        .valid_data_out (b_valid_data_out),
        .ready_data_out (b_ready_data_out)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: each 8-bit lane plus one, clamped or wrapped past 255.
    function automatic logic [DW-1:0] model_beat(input logic [DW-1:0] beat, input logic sat);
        logic [DW-1:0] r;
        r = '0;
        for (int k = 0; k < L; k++) begin
            int a;
            int s;
            a = int'(beat[k*W +: W]);
            s = a + 1;
            if (s > (1 << W) - 1) s = sat ? (1 << W) - 1 : s - (1 << W);
            r[k*W +: W] = W'(s);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [DW-1:0] data, input logic sat, input logic vld);
        I             = data;
        sat_mode      = sat;
        valid_data_in = vld;
    endtask

    // Scoreboard: records accepted beats, matches delivered beats in order,
    // and checks CE gating and output stability under stall.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (RESET) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (!CE) begin
                    checkOutput("ce_gate", 64'({ready_data_in, valid_data_out}), 64'd0);
                end
                if (prev_stall && CE) begin
                    checkOutput("stall_valid", 64'(valid_data_out), 64'd1);
                    checkOutput("stall_data", 64'(O), 64'(prev_o));
                end
                if (valid_data_in && ready_data_in) begin
                    exp_q.push_back(model_beat(I, sat_mode));
                    in_count++;
                end
                if (valid_data_out && ready_data_out) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_beat", 64'(O), 64'd0);
                        checkOutput("unexpected_beat_flag", 64'd1, 64'd0);
                    end else begin
                        checkOutput("beat_data", 64'(O), 64'(exp_q.pop_front()));
                    end
                    out_count++;
                end
                prev_stall = valid_data_out && !ready_data_out;
                prev_o     = O;
            end
        end
    end

    // Wide instance: one beat through the 4-deep pipe with a latency check.
    task automatic b_run(input logic [BDW-1:0] data, input logic sat, input logic [BDW-1:0] expv);
        b_I = data;
        b_sat_mode = sat;
        b_valid_data_in = 1'b1;
        #1;
        checkOutput("b_ready_in", 64'(b_ready_data_in), 64'd1);
        tick();
        b_valid_data_in = 1'b0;
        tick();
        tick();
        checkOutput("b_latency_early", 64'(b_valid_data_out), 64'd0);
        tick();
        checkOutput("b_latency", 64'(b_valid_data_out), 64'd1);
        checkOutput("b_data", 64'(b_O), 64'(expv));
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [DW-1:0] bp [3];
        int idx;
        int snap_in, snap_out;
        bit accepted;

        RESET = 1'b1; CE = 1'b1; ready_data_out = 1'b1;
        applyStimulus('0, 1'b0, 1'b0);
        b_ce = 1'b1; b_ready_data_out = 1'b1; b_I = '0; b_sat_mode = 1'b0; b_valid_data_in = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        #1;
        checkOutput("reset_o", 64'(O), 64'd0);
        checkOutput("reset_valid", 64'(valid_data_out), 64'd0);
        checkOutput("reset_ready", 64'(ready_data_in), 64'd1);
        checkOutput("b_reset_valid", 64'(b_valid_data_out), 64'd0);
        mon_en = 1'b1;

        // Wide configuration: saturate and wrap on 16-bit lanes with INCR 0x0100.
        b_run(48'hFF00_1234_FF80, 1'b1, 48'hFFFF_1334_FFFF);
        b_run(48'hFF00_1234_FF80, 1'b0, 48'h0000_1334_0080);

        // Streaming: first-beat latency and values.
        applyStimulus(32'hFE7F_0500, 1'b0, 1'b1);
        tick();
        valid_data_in = 1'b0;
        checkOutput("latency_early", 64'(valid_data_out), 64'd0);
        tick();
        checkOutput("latency", 64'(valid_data_out), 64'd1);
        checkOutput("stream_data", 64'(O), 64'h0000_0000_FF80_0601);
        tick();

        // Back-to-back beats at one per cycle.
        snap_out = out_count;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(DW'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            checkOutput("throughput_ready", 64'(ready_data_in), 64'd1);
            tick();
        end
        valid_data_in = 1'b0;
        repeat (4) tick();
        checkOutput("throughput_count", 64'(out_count - snap_out), 64'd8);
        checkOutput("throughput_empty", 64'(exp_q.size()), 64'd0);

        // Wrap versus saturate on the same beat.
        applyStimulus(32'h1234_56FF, 1'b0, 1'b1);
        tick();
        sat_mode = 1'b1;
        tick();
        valid_data_in = 1'b0;
        checkOutput("wrap_lane", 64'(O), 64'h1335_5700);
        tick();
        checkOutput("sat_lane", 64'(O), 64'h1335_57FF);
        tick();

        // Backpressure: only two beats fit, output holds, then a pass-through.
        ready_data_out = 1'b0;
        for (int i = 0; i < 3; i++) bp[i] = DW'($urandom);
        idx = 0;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(bp[idx], 1'b0, 1'b1);
            accepted = ready_data_in;
            tick();
            if (accepted) idx++;
        end
        checkOutput("bp_accepted", 64'(idx), 64'd2);
        applyStimulus(bp[2], 1'b0, 1'b1);
        checkOutput("bp_full", 64'(ready_data_in), 64'd0);
        checkOutput("bp_hold", 64'(O), 64'(model_beat(bp[0], 1'b0)));
        tick();
        tick();
        checkOutput("bp_stable", 64'(O), 64'(model_beat(bp[0], 1'b0)));
        ready_data_out = 1'b1;
        #1;
        checkOutput("bp_passthrough", 64'({ready_data_in, valid_data_out}), 64'd3);
        tick();
        valid_data_in = 1'b0;
        repeat (3) tick();
        checkOutput("bp_drained", 64'(exp_q.size()), 64'd0);

        // Clock-enable gating in the middle of a stream.
        snap_in = 0; snap_out = 0;
        for (int c = 0; c < 10; c++) begin
            CE = !(c >= 4 && c <= 6);
            applyStimulus(DW'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            if (c == 4) begin
                snap_in = in_count;
                snap_out = out_count;
            end
            if (c == 7) begin
                checkOutput("ce_in_frozen", 64'(in_count), 64'(snap_in));
                checkOutput("ce_out_frozen", 64'(out_count), 64'(snap_out));
            end
            tick();
        end
        CE = 1'b1;
        valid_data_in = 1'b0;
        repeat (4) tick();
        checkOutput("ce_drained", 64'(exp_q.size()), 64'd0);

        // Reset with two beats in flight, CE low to show RESET wins.
        ready_data_out = 1'b0;
        applyStimulus(DW'($urandom), 1'b0, 1'b1);
        tick();
        applyStimulus(DW'($urandom), 1'b1, 1'b1);
        tick();
        valid_data_in = 1'b0;
        RESET = 1'b1;
        CE = 1'b0;
        tick();
        RESET = 1'b0;
        CE = 1'b1;
        ready_data_out = 1'b1;
        snap_out = out_count;
        #1;
        checkOutput("rst_valid", 64'(valid_data_out), 64'd0);
        checkOutput("rst_data", 64'(O), 64'd0);
        checkOutput("rst_ready", 64'(ready_data_in), 64'd1);
        repeat (4) tick();
        checkOutput("rst_discard", 64'(out_count), 64'(snap_out));

        // Randomized traffic with random enable and backpressure.
        for (int c = 0; c < 400; c++) begin
            CE = ($urandom_range(0, 9) != 0);
            ready_data_out = ($urandom_range(0, 9) < 7);
            applyStimulus(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end
        CE = 1'b1;
        ready_data_out = 1'b1;
        valid_data_in = 1'b0;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        tick();
        checkOutput("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule

// File: doc/parallel_add_pipe.md
Name: parallel_add_pipe

Overview:
Parametrised successor to the fixed 4-lane, 8-bit "+1" datapath. Adds a constant INCR to each of LANES independent WIDTH-bit lanes, with per-beat wrap/saturate mode, through a STAGES-deep registered pipeline with full valid/ready backpressure and bubble collapsing. Sits between ready/valid producers and consumers in the streaming app layer, replacing the combinational pass-through handshake.

Parameters:
WIDTH, 8, lane data width in bits (>=1)
LANES, 4, number of parallel lanes (>=1)
STAGES, 2, pipeline register depth; equals zero-stall latency (>=1)
INCR, 1, constant added to every lane, truncated to WIDTH bits

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  synchronous, active-high reset
CE  input  1  clock enable; 0 freezes all state
I  input  LANES*WIDTH  lane k at bits [k*WIDTH +: WIDTH]
sat_mode  input  1  per-beat mode: 0 wrap, 1 saturate; sampled with I
valid_data_in  input  1  upstream beat valid
ready_data_in  output  1  block can accept a beat this cycle
O  output  LANES*WIDTH  result lanes, same packing as I
valid_data_out  output  1  O holds a valid beat
ready_data_out  input  1  downstream accepts beat

Behaviour:
- Clock CLK; reset RESET is synchronous and active-high. Single clock domain.
- Reset: all stage valid bits = 0, all stage data registers = 0; hence O = 0, valid_data_out = 0. RESET takes priority over CE.
- Stage s (0..STAGES-1) holds v[s] and data d[s]. Stage 0 captures the computed result; stages 1.. are pure registers; O = d[STAGES-1].
- Arithmetic per lane: sum = {1'b0,I_k} + INCR (WIDTH+1 bits). Wrap: result = sum[WIDTH-1:0]. Saturate: result = all-ones if sum[WIDTH] else sum[WIDTH-1:0]. No cross-lane carry.
- Advance chain (combinational): adv[STAGES-1] = ready_data_out | ~v[STAGES-1]; adv[s] = adv[s+1] | ~v[s]. Bubbles collapse; no stage is ever overwritten while valid and stalled.
- ready_data_in = CE & adv[0]. valid_data_out = CE & v[STAGES-1].
- Input handshake: valid_data_in & ready_data_in. Output handshake: valid_data_out & ready_data_out.
- When CE=1 and adv[s]: stage s loads from s-1 (stage 0 loads the computed result and valid_data_in). When adv[s] is 0, stage s holds.
- When CE=0: no register changes. Both ready_data_in and valid_data_out read 0, so no handshake can complete.
- Latency: a beat accepted in cycle t appears with valid_data_out at t+STAGES when there are no stalls. Throughput: 1 beat/cycle with ready_data_out held high.
- Capacity: STAGES beats. When full and ready_data_out=0, ready_data_in=0. When full and ready_data_out=1, an input and an output transfer complete in the same cycle.
- Ordering: strict FIFO; no beat dropped or duplicated.
- Data under stall: O and valid_data_out stay stable while valid_data_out=1 and ready_data_out=0, and CE=1.
- RESET mid-stream: all in-flight beats are discarded; valid_data_out=0 the following cycle.
- Combinational paths: ready_data_out -> ready_data_in through the adv chain, depth STAGES. There is no combinational path from valid_data_in to valid_data_out.

Decomposition:
- Shared package parallel_add_pkg: mode constants MODE_WRAP=0 and MODE_SAT=1; function lane_add(a, incr, sat) parametrised by WIDTH.
- One sub-module, parallel_add_lane: combinational WIDTH-bit add with wrap/saturate, instantiated LANES times by generate.
- The pipeline stage registers and the adv chain live in the top module.

Test Plan:
- Reset then idle: RESET=1 for 2 cycles, CE=1 -> O=0, valid_data_out=0, ready_data_in=1 (defaults W=8, L=4, S=2).
- Streaming: I lanes {0x00,0x05,0x7F,0xFE}, sat_mode=0, ready_data_out=1 -> two cycles later O={0x01,0x06,0x80,0xFF}, valid_data_out=1; continuous input gives 1 beat/cycle.
- Wrap vs saturate: lane 0xFF with sat_mode=0 -> 0x00; the same beat with sat_mode=1 -> 0xFF; other lanes unaffected.
- Backpressure: ready_data_out=0, push 3 beats -> 2 accepted, then ready_data_in=0 with O stable. Raise ready_data_out -> beats emerge in order, no loss or duplication; a simultaneous in/out transfer at full completes.
- CE gating: CE=0 for 3 cycles mid-stream -> no state change, ready_data_in=0, valid_data_out=0; on CE=1 the stream resumes intact.
- Reset mid-stream with 2 beats in flight: RESET=1 for one cycle -> valid_data_out=0 next cycle and those beats never appear. Also rerun with W=16, L=3, S=4, INCR=0x0100 -> lane 0xFF80 saturates to 0xFFFF.
